// File: rtl/pipe_pkg.sv
// Shared decode-stage constants: instruction field positions, NOP encoding, forward-select codes.
package pipe_pkg;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned RS_LSB  = 5;
    localparam int unsigned RT_LSB  = 0;
    localparam int unsigned IMM_LSB = 10;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned JIDX_W  = 26;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_EX,
        FWD_MEM,
        FWD_WB
    } fwd_sel_e;

endpackage

// File: rtl/pipe_fwd_mux.sv
// Operand bypass mux: picks the register file value or a younger in-flight result.
module pipe_fwd_mux
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  fwd_sel_e          sel_i,
    input  logic [XLEN-1:0]   rf_i,
    input  logic [XLEN-1:0]   ex_i,
    input  logic [XLEN-1:0]   mem_i,
    input  logic [XLEN-1:0]   wb_i,
    output logic [XLEN-1:0]   q_o
);

    always_comb begin
        q_o = rf_i;
        unique case (sel_i)
            FWD_RF:  q_o = rf_i;
            FWD_EX:  q_o = ex_i;
            FWD_MEM: q_o = mem_i;
            FWD_WB:  q_o = wb_i;
            default: q_o = rf_i;
        endcase
    end

endmodule

// File: rtl/pipe_regfile_bypass.sv
// NREG x XLEN register file, two read ports, one write port; a same-cycle write is visible on reads.
module pipe_regfile_bypass
    import pipe_pkg::*;
#(
    parameter int unsigned NREG = 32,
    parameter int unsigned XLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [REG_W-1:0]  wn_i,
    input  logic [XLEN-1:0]   wd_i,
    input  logic [REG_W-1:0]  ra_i,
    input  logic [REG_W-1:0]  rb_i,
    output logic [XLEN-1:0]   qa_o,
    output logic [XLEN-1:0]   qb_o
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic            wr_ok;

    // Writes to r0 or beyond the implemented range are dropped.
    assign wr_ok = we_i && (wn_i != '0) && (32'(wn_i) < NREG);

    always_comb begin
        regs_d = regs_q;
        for (int unsigned i = 1; i < NREG; i++) begin
            if (wr_ok && (wn_i == REG_W'(i))) regs_d[i] = wd_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        qa_o = '0;
        qb_o = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            if (ra_i == REG_W'(i)) qa_o = regs_q[i];
            if (rb_i == REG_W'(i)) qb_o = regs_q[i];
        end
        if (wr_ok && (ra_i == wn_i)) qa_o = wd_i;
        if (wr_ok && (rb_i == wn_i)) qb_o = wd_i;
    end

endmodule

// File: rtl/pipe_id_fwd_stage.sv
// Decode stage: IF/ID register, operand forwarding, load-use interlock and branch/jump resolution.
module pipe_id_fwd_stage
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned FWD_EN = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic [31:0]       IFinst,
    input  logic [XLEN-1:0]   IFp4,
    input  logic              dec_use_rs,
    input  logic              dec_use_rt,
    input  logic              dec_branch,
    input  logic              dec_bne,
    input  logic              dec_jump,
    input  logic              EXwreg,
    input  logic              EXm2reg,
    input  logic [4:0]        EXwn,
    input  logic [XLEN-1:0]   EXalu,
    input  logic              MEMwreg,
    input  logic              MEMm2reg,
    input  logic [4:0]        MEMwn,
    input  logic [XLEN-1:0]   MEMalu,
    input  logic [XLEN-1:0]   MEMdata,
    input  logic              WBwreg,
    input  logic [4:0]        WBwn,
    input  logic [XLEN-1:0]   WBdata,
    output logic [31:0]       IDinst,
    output logic [XLEN-1:0]   IDp4,
    output logic [XLEN-1:0]   IDqa,
    output logic [XLEN-1:0]   IDqb,
    output logic              IFwpc,
    output logic              IDbubble,
    output logic              IDredirect,
    output logic [XLEN-1:0]   IDtarget,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic [31:0]      inst_q, inst_d;
    logic [XLEN-1:0]  p4_q, p4_d;
    logic [CNT_W-1:0] scnt_q, scnt_d, fcnt_q, fcnt_d;

    logic [REG_W-1:0] src [2];
    logic [XLEN-1:0]  rf_q [2];
    fwd_sel_e         sel [2];
    logic [1:0]       used, ex_hit, mem_hit, wb_hit, hz;
    logic [XLEN-1:0]  mem_val, br_tgt, j_tgt;
    logic [IMM_W-1:0] imm;
    logic             stall, br_taken;

    assign src[0]  = inst_q[RS_LSB +: REG_W];
    assign src[1]  = inst_q[RT_LSB +: REG_W];
    assign used    = {dec_use_rt, dec_use_rs};
    assign mem_val = MEMm2reg ? MEMdata : MEMalu;

    always_comb begin
        ex_hit  = '0;
        mem_hit = '0;
        wb_hit  = '0;
        hz      = '0;
        for (int i = 0; i < 2; i++) begin
            sel[i]     = FWD_RF;
            ex_hit[i]  = EXwreg  && (EXwn  == src[i]) && (src[i] != '0);
            mem_hit[i] = MEMwreg && (MEMwn == src[i]) && (src[i] != '0);
            wb_hit[i]  = WBwreg  && (WBwn  == src[i]) && (src[i] != '0);
            if (FWD_EN != 0) begin
                // A load in EX has no data yet; it stalls and is picked up from MEM next cycle.
                if (ex_hit[i] && !EXm2reg) sel[i] = FWD_EX;
                else if (mem_hit[i])       sel[i] = FWD_MEM;
                else if (wb_hit[i])        sel[i] = FWD_WB;
                hz[i] = used[i] && ex_hit[i] && EXm2reg;
            end else begin
                if (wb_hit[i]) sel[i] = FWD_WB;
                hz[i] = used[i] && (ex_hit[i] || mem_hit[i]);
            end
        end
    end

    pipe_regfile_bypass #(
        .NREG (NREG),
        .XLEN (XLEN)
    ) u_regfile (
        .clk_i  (clk),
        .rst_ni (clrn),
        .we_i   (WBwreg),
        .wn_i   (WBwn),
        .wd_i   (WBdata),
        .ra_i   (src[0]),
        .rb_i   (src[1]),
        .qa_o   (rf_q[0]),
        .qb_o   (rf_q[1])
    );

    pipe_fwd_mux #(.XLEN(XLEN)) u_fwd_a (
        .sel_i (sel[0]),
        .rf_i  (rf_q[0]),
        .ex_i  (EXalu),
        .mem_i (mem_val),
        .wb_i  (WBdata),
        .q_o   (IDqa)
    );

    pipe_fwd_mux #(.XLEN(XLEN)) u_fwd_b (
        .sel_i (sel[1]),
        .rf_i  (rf_q[1]),
        .ex_i  (EXalu),
        .mem_i (mem_val),
        .wb_i  (WBdata),
        .q_o   (IDqb)
    );

    assign stall    = |hz;
    assign imm      = inst_q[IMM_LSB +: IMM_W];
    assign br_tgt   = p4_q + {{(XLEN-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
    assign j_tgt    = {p4_q[XLEN-1:28], inst_q[JIDX_W-1:0], 2'b00};
    assign br_taken = dec_branch && ((IDqa == IDqb) ^ dec_bne);

    // Redirect is suppressed while stalled: the branch resolves once its operands are valid.
    assign IDredirect = !stall && (dec_jump || br_taken);
    assign IDtarget   = dec_jump ? j_tgt : br_tgt;
    assign IFwpc      = !stall;
    assign IDbubble   = stall;
    assign IDinst     = inst_q;
    assign IDp4       = p4_q;
    assign stall_cnt  = scnt_q;
    assign flush_cnt  = fcnt_q;

    always_comb begin
        inst_d = IFinst;
        p4_d   = IFp4;
        if (stall) begin
            inst_d = inst_q;
            p4_d   = p4_q;
        end else if (IDredirect) begin
            inst_d = NOP;
            p4_d   = '0;
        end
        scnt_d = (stall && (scnt_q != '1)) ? scnt_q + CNT_W'(1) : scnt_q;
        fcnt_d = (IDredirect && (fcnt_q != '1)) ? fcnt_q + CNT_W'(1) : fcnt_q;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            inst_q <= NOP;
            p4_q   <= '0;
            scnt_q <= '0;
            fcnt_q <= '0;
        end else begin
            inst_q <= inst_d;
            p4_q   <= p4_d;
            scnt_q <= scnt_d;
            fcnt_q <= fcnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_id_fwd_stage.sv
// Directed bench: instance 0 full forwarding, 1 interlock-only, 2 full forwarding with 2-bit counters.
module tb_pipe_id_fwd_stage;

    logic clk = 1'b0;
    logic clrn = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] IFinst, IFp4, EXalu, MEMalu, MEMdata, WBdata;
    logic        dec_use_rs, dec_use_rt, dec_branch, dec_bne, dec_jump;
    logic        EXwreg, EXm2reg, MEMwreg, MEMm2reg, WBwreg;
    logic [4:0]  EXwn, MEMwn, WBwn;

    logic [31:0] o_inst [3];
    logic [31:0] o_p4   [3];
    logic [31:0] o_qa   [3];
    logic [31:0] o_qb   [3];
    logic [31:0] o_tgt  [3];
    logic        o_wpc  [3];
    logic        o_bub  [3];
    logic        o_red  [3];
    logic [15:0] o_scnt [2];
    logic [15:0] o_fcnt [2];
    logic [1:0]  c2_scnt, c2_fcnt;

    int compared = 0;
    int mismatched = 0;

    pipe_id_fwd_stage dut (
        .clk(clk), .clrn(clrn), .IFinst(IFinst), .IFp4(IFp4),
        .dec_use_rs(dec_use_rs), .dec_use_rt(dec_use_rt), .dec_branch(dec_branch),
        .dec_bne(dec_bne), .dec_jump(dec_jump),
        .EXwreg(EXwreg), .EXm2reg(EXm2reg), .EXwn(EXwn), .EXalu(EXalu),
        .MEMwreg(MEMwreg), .MEMm2reg(MEMm2reg), .MEMwn(MEMwn), .MEMalu(MEMalu),
        .MEMdata(MEMdata), .WBwreg(WBwreg), .WBwn(WBwn), .WBdata(WBdata),
        .IDinst(o_inst[0]), .IDp4(o_p4[0]), .IDqa(o_qa[0]), .IDqb(o_qb[0]),
        .IFwpc(o_wpc[0]), .IDbubble(o_bub[0]), .IDredirect(o_red[0]), .IDtarget(o_tgt[0]),
        .stall_cnt(o_scnt[0]), .flush_cnt(o_fcnt[0])
    );

    pipe_id_fwd_stage #(.FWD_EN(0)) dut_nf (
        .clk(clk), .clrn(clrn), .IFinst(IFinst), .IFp4(IFp4),
        .dec_use_rs(dec_use_rs), .dec_use_rt(dec_use_rt), .dec_branch(dec_branch),
        .dec_bne(dec_bne), .dec_jump(dec_jump),
        .EXwreg(EXwreg), .EXm2reg(EXm2reg), .EXwn(EXwn), .EXalu(EXalu),
        .MEMwreg(MEMwreg), .MEMm2reg(MEMm2reg), .MEMwn(MEMwn), .MEMalu(MEMalu),
        .MEMdata(MEMdata), .WBwreg(WBwreg), .WBwn(WBwn), .WBdata(WBdata),
        .IDinst(o_inst[1]), .IDp4(o_p4[1]), .IDqa(o_qa[1]), .IDqb(o_qb[1]),
        .IFwpc(o_wpc[1]), .IDbubble(o_bub[1]), .IDredirect(o_red[1]), .IDtarget(o_tgt[1]),
        .stall_cnt(o_scnt[1]), .flush_cnt(o_fcnt[1])
    );

    pipe_id_fwd_stage #(.CNT_W(2)) dut_c2 (
        .clk(clk), .clrn(clrn), .IFinst(IFinst), .IFp4(IFp4),
        .dec_use_rs(dec_use_rs), .dec_use_rt(dec_use_rt), .dec_branch(dec_branch),
        .dec_bne(dec_bne), .dec_jump(dec_jump),
        .EXwreg(EXwreg), .EXm2reg(EXm2reg), .EXwn(EXwn), .EXalu(EXalu),
        .MEMwreg(MEMwreg), .MEMm2reg(MEMm2reg), .MEMwn(MEMwn), .MEMalu(MEMalu),
        .MEMdata(MEMdata), .WBwreg(WBwreg), .WBwn(WBwn), .WBdata(WBdata),
        .IDinst(o_inst[2]), .IDp4(o_p4[2]), .IDqa(o_qa[2]), .IDqb(o_qb[2]),
        .IFwpc(o_wpc[2]), .IDbubble(o_bub[2]), .IDredirect(o_red[2]), .IDtarget(o_tgt[2]),
        .stall_cnt(c2_scnt), .flush_cnt(c2_fcnt)
    );

    function automatic logic [31:0] mk(input logic [15:0] imm, input logic [4:0] rs,
                                       input logic [4:0] rt);
        return {6'b0, imm, rs, rt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        IFinst = '0; IFp4 = '0; EXalu = '0; MEMalu = '0; MEMdata = '0; WBdata = '0;
        dec_use_rs = 0; dec_use_rt = 0; dec_branch = 0; dec_bne = 0; dec_jump = 0;
        EXwreg = 0; EXm2reg = 0; MEMwreg = 0; MEMm2reg = 0; WBwreg = 0;
        EXwn = '0; MEMwn = '0; WBwn = '0;
        clrn = 1'b0;
        tick();
        clrn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        compared++; if (o_inst[0] !== 32'h0) begin mismatched++; $display("FAIL reset_inst: got %h want %h", o_inst[0], 32'h0); end
        compared++; if (o_p4[0] !== 32'h0) begin mismatched++; $display("FAIL reset_p4: got %h want %h", o_p4[0], 32'h0); end
        compared++; if (o_qa[0] !== 32'h0) begin mismatched++; $display("FAIL reset_qa: got %h want %h", o_qa[0], 32'h0); end
        compared++; if (o_wpc[0] !== 1'b1) begin mismatched++; $display("FAIL reset_wpc: got %b want 1", o_wpc[0]); end
        compared++; if (o_bub[0] !== 1'b0) begin mismatched++; $display("FAIL reset_bubble: got %b want 0", o_bub[0]); end
        compared++; if (o_red[0] !== 1'b0) begin mismatched++; $display("FAIL reset_redirect: got %b want 0", o_red[0]); end
        compared++; if (o_scnt[0] !== 16'h0) begin mismatched++; $display("FAIL reset_stall_cnt: got %0d want 0", o_scnt[0]); end
        compared++; if (o_fcnt[0] !== 16'h0) begin mismatched++; $display("FAIL reset_flush_cnt: got %0d want 0", o_fcnt[0]); end
    endtask

    task automatic test_wb_writethrough();
        do_reset();
        IFinst = mk(16'h0, 5'd3, 5'd0); dec_use_rs = 1;
        tick();
        WBwreg = 1; WBwn = 5'd3; WBdata = 32'h1234;
        #1;
        compared++; if (o_qa[0] !== 32'h1234) begin mismatched++; $display("FAIL wb_same_cycle: got %h want %h", o_qa[0], 32'h1234); end
        tick();
        WBwreg = 0;
        #1;
        compared++; if (o_qa[0] !== 32'h1234) begin mismatched++; $display("FAIL wb_stored: got %h want %h", o_qa[0], 32'h1234); end
        IFinst = mk(16'h0, 5'd0, 5'd3);
        tick();
        WBwreg = 1; WBwn = 5'd0; WBdata = 32'hDEAD;
        #1;
        compared++; if (o_qa[0] !== 32'h0) begin mismatched++; $display("FAIL r0_write_fwd: got %h want %h", o_qa[0], 32'h0); end
        compared++; if (o_qb[0] !== 32'h1234) begin mismatched++; $display("FAIL r3_rt_read: got %h want %h", o_qb[0], 32'h1234); end
        tick();
        WBwreg = 0;
        #1;
        compared++; if (o_qa[0] !== 32'h0) begin mismatched++; $display("FAIL r0_stored: got %h want %h", o_qa[0], 32'h0); end
    endtask

    task automatic test_ex_forward();
        do_reset();
        IFinst = mk(16'h0, 5'd5, 5'd0); dec_use_rs = 1;
        tick();
        IFinst = '0;
        EXwreg = 1; EXwn = 5'd5; EXalu = 32'hA;
        #1;
        compared++; if (o_qa[0] !== 32'hA) begin mismatched++; $display("FAIL ex_fwd_qa: got %h want %h", o_qa[0], 32'hA); end
        compared++; if (o_bub[0] !== 1'b0) begin mismatched++; $display("FAIL ex_fwd_nostall: got %b want 0", o_bub[0]); end
        compared++; if (o_wpc[1] !== 1'b0) begin mismatched++; $display("FAIL nf_ex_wpc: got %b want 0", o_wpc[1]); end
        compared++; if (o_bub[1] !== 1'b1) begin mismatched++; $display("FAIL nf_ex_bubble: got %b want 1", o_bub[1]); end
        tick();
        EXwreg = 0; MEMwreg = 1; MEMwn = 5'd5; MEMalu = 32'hA;
        #1;
        compared++; if (o_bub[1] !== 1'b1) begin mismatched++; $display("FAIL nf_mem_bubble: got %b want 1", o_bub[1]); end
        compared++; if (o_inst[1] !== mk(16'h0, 5'd5, 5'd0)) begin mismatched++; $display("FAIL nf_hold_inst: got %h want %h", o_inst[1], mk(16'h0, 5'd5, 5'd0)); end
        tick();
        MEMwreg = 0; WBwreg = 1; WBwn = 5'd5; WBdata = 32'hA;
        #1;
        compared++; if (o_bub[1] !== 1'b0) begin mismatched++; $display("FAIL nf_wb_nostall: got %b want 0", o_bub[1]); end
        compared++; if (o_qa[1] !== 32'hA) begin mismatched++; $display("FAIL nf_wb_qa: got %h want %h", o_qa[1], 32'hA); end
        compared++; if (o_scnt[1] !== 16'd2) begin mismatched++; $display("FAIL nf_stall_cnt: got %0d want 2", o_scnt[1]); end
        compared++; if (o_scnt[0] !== 16'd0) begin mismatched++; $display("FAIL fwd_stall_cnt: got %0d want 0", o_scnt[0]); end
    endtask

    task automatic test_load_use();
        do_reset();
        IFinst = mk(16'h0, 5'd7, 5'd0); dec_use_rs = 1;
        tick();
        IFinst = '0;
        EXwreg = 1; EXm2reg = 1; EXwn = 5'd7;
        #1;
        compared++; if (o_wpc[0] !== 1'b0) begin mismatched++; $display("FAIL ld_use_wpc: got %b want 0", o_wpc[0]); end
        compared++; if (o_bub[0] !== 1'b1) begin mismatched++; $display("FAIL ld_use_bubble: got %b want 1", o_bub[0]); end
        tick();
        EXwreg = 0; EXm2reg = 0;
        MEMwreg = 1; MEMm2reg = 1; MEMwn = 5'd7; MEMdata = 32'h55AA; MEMalu = 32'h1111;
        #1;
        compared++; if (o_wpc[0] !== 1'b1) begin mismatched++; $display("FAIL ld_resume_wpc: got %b want 1", o_wpc[0]); end
        compared++; if (o_qa[0] !== 32'h55AA) begin mismatched++; $display("FAIL ld_mem_fwd: got %h want %h", o_qa[0], 32'h55AA); end
        compared++; if (o_inst[0] !== mk(16'h0, 5'd7, 5'd0)) begin mismatched++; $display("FAIL ld_hold_inst: got %h want %h", o_inst[0], mk(16'h0, 5'd7, 5'd0)); end
        compared++; if (o_scnt[0] !== 16'd1) begin mismatched++; $display("FAIL ld_stall_cnt: got %0d want 1", o_scnt[0]); end
    endtask

    task automatic test_branch();
        do_reset();
        dec_use_rs = 1; dec_use_rt = 1;
        WBwreg = 1; WBwn = 5'd1; WBdata = 32'h42;
        tick();
        WBwn = 5'd2;
        IFinst = mk(16'hFFFF, 5'd1, 5'd2); IFp4 = 32'h100;
        tick();
        WBwreg = 0; IFinst = 32'h1234_5678; IFp4 = 32'h104;
        dec_branch = 1; dec_bne = 1;
        #1;
        compared++; if (o_red[0] !== 1'b0) begin mismatched++; $display("FAIL bne_equal_redirect: got %b want 0", o_red[0]); end
        dec_bne = 0;
        #1;
        compared++; if (o_red[0] !== 1'b1) begin mismatched++; $display("FAIL beq_redirect: got %b want 1", o_red[0]); end
        compared++; if (o_tgt[0] !== 32'hFC) begin mismatched++; $display("FAIL beq_target: got %h want %h", o_tgt[0], 32'hFC); end
        tick();
        dec_branch = 0;
        #1;
        compared++; if (o_inst[0] !== 32'h0) begin mismatched++; $display("FAIL squash_inst: got %h want %h", o_inst[0], 32'h0); end
        compared++; if (o_fcnt[0] !== 16'd1) begin mismatched++; $display("FAIL flush_cnt1: got %0d want 1", o_fcnt[0]); end
        IFinst = 32'h0000_0040; IFp4 = 32'hA000_0010;
        tick();
        IFinst = '0; IFp4 = '0;
        dec_jump = 1; dec_branch = 1; dec_bne = 1;
        #1;
        compared++; if (o_red[0] !== 1'b1) begin mismatched++; $display("FAIL jump_redirect: got %b want 1", o_red[0]); end
        compared++; if (o_tgt[0] !== 32'hA000_0100) begin mismatched++; $display("FAIL jump_target: got %h want %h", o_tgt[0], 32'hA000_0100); end
        tick();
        dec_jump = 0; dec_branch = 0; dec_bne = 0;
        #1;
        compared++; if (o_fcnt[0] !== 16'd2) begin mismatched++; $display("FAIL flush_cnt2: got %0d want 2", o_fcnt[0]); end
    endtask

    task automatic test_branch_load();
        do_reset();
        IFinst = mk(16'h0004, 5'd1, 5'd2); IFp4 = 32'h200;
        dec_use_rs = 1; dec_use_rt = 1;
        tick();
        IFinst = '0; IFp4 = '0;
        dec_branch = 1;
        EXwreg = 1; EXm2reg = 1; EXwn = 5'd1;
        #1;
        compared++; if (o_red[0] !== 1'b0) begin mismatched++; $display("FAIL br_ld_redirect: got %b want 0", o_red[0]); end
        compared++; if (o_bub[0] !== 1'b1) begin mismatched++; $display("FAIL br_ld_bubble: got %b want 1", o_bub[0]); end
        tick();
        EXwreg = 0; EXm2reg = 0;
        MEMwreg = 1; MEMm2reg = 1; MEMwn = 5'd1; MEMdata = 32'h0; MEMalu = 32'h77;
        #1;
        compared++; if (o_red[0] !== 1'b1) begin mismatched++; $display("FAIL br_ld_resolve: got %b want 1", o_red[0]); end
        compared++; if (o_tgt[0] !== 32'h210) begin mismatched++; $display("FAIL br_ld_target: got %h want %h", o_tgt[0], 32'h210); end
        dec_branch = 0; MEMwreg = 0; MEMm2reg = 0;
    endtask

    task automatic test_counter_sat();
        do_reset();
        IFinst = mk(16'h0, 5'd7, 5'd0); dec_use_rs = 1;
        tick();
        IFinst = '0;
        EXwreg = 1; EXm2reg = 1; EXwn = 5'd7;
        repeat (5) tick();
        compared++; if (c2_scnt !== 2'd3) begin mismatched++; $display("FAIL sat_cnt_c2: got %0d want 3", c2_scnt); end
        compared++; if (o_scnt[0] !== 16'd5) begin mismatched++; $display("FAIL stall_cnt5: got %0d want 5", o_scnt[0]); end
        clrn = 1'b0;
        #1;
        compared++; if (c2_scnt !== 2'd0) begin mismatched++; $display("FAIL rst_mid_c2: got %0d want 0", c2_scnt); end
        compared++; if (o_scnt[0] !== 16'd0) begin mismatched++; $display("FAIL rst_mid_cnt: got %0d want 0", o_scnt[0]); end
        compared++; if (o_inst[0] !== 32'h0) begin mismatched++; $display("FAIL rst_mid_inst: got %h want %h", o_inst[0], 32'h0); end
        compared++; if (o_wpc[0] !== 1'b1) begin mismatched++; $display("FAIL rst_mid_wpc: got %b want 1", o_wpc[0]); end
        tick();
        clrn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_wb_writethrough();
        test_ex_forward();
        test_load_use();
        test_branch();
        test_branch_load();
        test_counter_sat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
